// File: rtl/ide_pkg.sv
// Shared encodings for the IDE ping-pong sector buffer: bank ownership,
// transfer direction and sticky error bit positions.
package ide_pkg;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_BUS = 1'b1
    } owner_e;

    typedef enum logic {
        DIR_BUS_READ  = 1'b0,
        DIR_BUS_WRITE = 1'b1
    } dir_e;

    localparam int ERR_BUS = 0;
    localparam int ERR_CPU = 1;

endpackage

// File: rtl/ide_pingpong_ram.sv
// Two-bank sector RAM: byte-lane CPU port and word-wide bus port, both with
// registered reads. Address is {bank, word offset}.
module ide_pingpong_ram #(
    parameter int AW = 8
) (
    input  logic          i_clk,
    input  logic          i_rst_,
    input  logic [AW:0]   i_cpu_addr,
    input  logic [7:0]    i_cpu_wdata,
    input  logic          i_cpu_we_hi,
    input  logic          i_cpu_we_lo,
    input  logic          i_cpu_re,
    output logic [15:0]   o_cpu_rdata,
    input  logic [AW:0]   i_bus_addr,
    input  logic [15:0]   i_bus_wdata,
    input  logic          i_bus_we,
    output logic [15:0]   o_bus_rdata
);

    localparam int DEPTH = 2 ** (AW + 1);

    logic [15:0] r_mem [DEPTH];
    logic [15:0] r_cpu_q;
    logic [15:0] r_bus_q;

    // Ownership guarantees the two ports never write the same word in one cycle.
    always_ff @(posedge i_clk) begin
        if (i_cpu_we_lo) r_mem[i_cpu_addr][7:0]  <= i_cpu_wdata;
        if (i_cpu_we_hi) r_mem[i_cpu_addr][15:8] <= i_cpu_wdata;
        if (i_bus_we)    r_mem[i_bus_addr]       <= i_bus_wdata;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_) begin
            r_cpu_q <= '0;
            r_bus_q <= '0;
        end else begin
            if (i_cpu_re) r_cpu_q <= r_mem[i_cpu_addr];
            r_bus_q <= r_mem[i_bus_addr];
        end
    end

    assign o_cpu_rdata = r_cpu_q;
    assign o_bus_rdata = r_bus_q;

endmodule

// File: rtl/ide_pingpong_buffer.sv
// Double-banked sector buffer between the IDE bus transfer logic and the
// 8-bit AVR port; each bank is owned by either the CPU or the bus side.
module ide_pingpong_buffer
    import ide_pkg::*;
#(
    parameter int AW = 8,
    parameter int LW = AW
) (
    input  logic          i_clk,
    input  logic          i_rst_,
    input  logic          i_enable,
    input  logic          i_dir,
    input  logic [LW-1:0] i_len,
    input  logic [AW:0]   i_cpu_a,
    input  logic [7:0]    i_cpu_d_in,
    input  logic          i_cpu_we,
    input  logic          i_cpu_re,
    output logic [7:0]    o_cpu_d_out,
    input  logic          i_cpu_commit,
    output logic          o_cpu_avail,
    output logic          o_cpu_bank,
    input  logic [15:0]   i_bus_d_in,
    output logic [15:0]   o_bus_d_out,
    input  logic          i_bus_strobe,
    output logic          o_bus_ready,
    output logic          o_bus_last,
    output logic          o_bank_done,
    output logic [1:0]    o_err,
    input  logic          i_err_clr
);

    owner_e        r_owner [2];
    logic [LW-1:0] r_len   [2];
    logic          r_cpu_bank;
    logic          r_bus_bank;
    logic [AW-1:0] r_bus_pos;
    dir_e          r_dir;
    logic          r_bank_done;
    logic [1:0]    r_err;
    logic          r_cpu_lane;

    logic          w_cpu_avail;
    logic          w_bus_ready;
    logic          w_bus_last_hit;
    logic          w_commit_ok;
    logic          w_strobe_ok;
    logic          w_cpu_wr_ok;
    logic          w_bus_wr;
    logic [1:0]    w_new_err;
    logic [15:0]   w_cpu_word;

    assign w_cpu_avail    = i_enable && (r_owner[r_cpu_bank] == OWN_CPU);
    assign w_bus_ready    = i_enable && (r_owner[r_bus_bank] == OWN_BUS);
    assign w_bus_last_hit = (r_bus_pos == r_len[r_bus_bank]);
    assign w_commit_ok    = i_cpu_commit && w_cpu_avail;
    assign w_strobe_ok    = i_bus_strobe && w_bus_ready;
    assign w_cpu_wr_ok    = i_rst_ && i_cpu_we && w_cpu_avail;
    assign w_bus_wr       = i_rst_ && w_strobe_ok && (r_dir == DIR_BUS_WRITE);

    always_comb begin
        w_new_err          = '0;
        w_new_err[ERR_BUS] = i_bus_strobe && !w_bus_ready;
        w_new_err[ERR_CPU] = (i_cpu_we || i_cpu_commit) && !w_cpu_avail;
    end

    // Reset and disable share the idle path; only reset touches err.
    always_ff @(posedge i_clk) begin
        if (!i_rst_ || !i_enable) begin
            r_cpu_bank  <= 1'b0;
            r_bus_bank  <= 1'b0;
            r_bus_pos   <= '0;
            r_bank_done <= 1'b0;
            r_dir       <= dir_e'(i_dir);
            for (int b = 0; b < 2; b++) begin
                r_owner[b] <= i_dir ? OWN_BUS : OWN_CPU;
                if (i_dir) r_len[b] <= i_len;
            end
            if (!i_rst_) r_err <= '0;
        end else begin
            r_bank_done <= w_strobe_ok && w_bus_last_hit;
            r_err       <= (i_err_clr ? 2'b00 : r_err) | w_new_err;
            if (w_commit_ok) begin
                r_owner[r_cpu_bank] <= OWN_BUS;
                r_len[r_cpu_bank]   <= i_len;
                r_cpu_bank          <= ~r_cpu_bank;
            end
            // A final strobe always targets the other bank than a same-cycle commit.
            if (w_strobe_ok) begin
                if (w_bus_last_hit) begin
                    r_owner[r_bus_bank] <= OWN_CPU;
                    r_bus_bank          <= ~r_bus_bank;
                    r_bus_pos           <= '0;
                end else begin
                    r_bus_pos <= r_bus_pos + AW'(1);
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_) begin
            r_cpu_lane <= 1'b0;
        end else if (i_cpu_re) begin
            r_cpu_lane <= i_cpu_a[0];
        end
    end

    ide_pingpong_ram #(
        .AW (AW)
    ) u_ram (
        .i_clk       (i_clk),
        .i_rst_      (i_rst_),
        .i_cpu_addr  ({r_cpu_bank, i_cpu_a[AW:1]}),
        .i_cpu_wdata (i_cpu_d_in),
        .i_cpu_we_hi (w_cpu_wr_ok && i_cpu_a[0]),
        .i_cpu_we_lo (w_cpu_wr_ok && !i_cpu_a[0]),
        .i_cpu_re    (i_cpu_re),
        .o_cpu_rdata (w_cpu_word),
        .i_bus_addr  ({r_bus_bank, r_bus_pos}),
        .i_bus_wdata (i_bus_d_in),
        .i_bus_we    (w_bus_wr),
        .o_bus_rdata (o_bus_d_out)
    );

    assign o_cpu_d_out = r_cpu_lane ? w_cpu_word[15:8] : w_cpu_word[7:0];
    assign o_cpu_avail = w_cpu_avail;
    assign o_cpu_bank  = r_cpu_bank;
    assign o_bus_ready = w_bus_ready;
    assign o_bus_last  = w_bus_ready && w_bus_last_hit;
    assign o_bank_done = r_bank_done;
    assign o_err       = r_err;

endmodule

// File: tb/tb_ide_pingpong_buffer.sv
// Self-checking bench for ide_pingpong_buffer: directed scenarios plus a
// randomized phase, all checked every cycle against a behavioural model.
module tb_ide_pingpong_buffer;

    localparam int AW = 8;
    localparam int WORDS = 2 ** AW;

    logic          clk = 1'b0;
    logic          rstN;
    logic          enable;
    logic          dir;
    logic [AW-1:0] len;
    logic [AW:0]   cpuA;
    logic [7:0]    cpuDIn;
    logic          cpuWe;
    logic          cpuRe;
    logic [7:0]    cpuDOut;
    logic          cpuCommit;
    logic          cpuAvail;
    logic          cpuBank;
    logic [15:0]   busDIn;
    logic [15:0]   busDOut;
    logic          busStrobe;
    logic          busReady;
    logic          busLast;
    logic          bankDone;
    logic [1:0]    err;
    logic          errClr;

    int checks = 0;
    int errors = 0;

    // Behavioural model: ownership, lengths, positions and sector contents.
    int          mOwn [2];
    int          mLen [2];
    int          mCpuBank, mBusBank, mPos, mDir, mErr;
    bit          mDone;
    logic [15:0] mMem [2][WORDS];
    bit   [1:0]  mKnown [2][WORDS];
    logic [7:0]  mCpuOut;
    bit          mCpuOutKnown;
    logic [15:0] mBusOut;
    bit          mBusOutKnown;

    ide_pingpong_buffer #(.AW(AW), .LW(AW)) dut (
        .i_clk        (clk),
        .i_rst_       (rstN),
        .i_enable     (enable),
        .i_dir        (dir),
        .i_len        (len),
        .i_cpu_a      (cpuA),
        .i_cpu_d_in   (cpuDIn),
        .i_cpu_we     (cpuWe),
        .i_cpu_re     (cpuRe),
        .o_cpu_d_out  (cpuDOut),
        .i_cpu_commit (cpuCommit),
        .o_cpu_avail  (cpuAvail),
        .o_cpu_bank   (cpuBank),
        .i_bus_d_in   (busDIn),
        .o_bus_d_out  (busDOut),
        .i_bus_strobe (busStrobe),
        .o_bus_ready  (busReady),
        .o_bus_last   (busLast),
        .o_bank_done  (bankDone),
        .o_err        (err),
        .i_err_clr    (errClr)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic modelStep();
        int  ob = mCpuBank;
        int  bb = mBusBank;
        int  w  = int'(cpuA[AW:1]);
        bit  avail = enable && (mOwn[ob] == 0);
        bit  ready = enable && (mOwn[bb] == 1);
        bit  last  = (mPos == mLen[bb]);
        int  newErr = 0;
        if (!rstN) begin
            mCpuOut = 8'h00;   mCpuOutKnown = 1'b1;
            mBusOut = 16'h0000; mBusOutKnown = 1'b1;
        end else begin
            if (cpuRe) begin
                mCpuOut      = cpuA[0] ? mMem[ob][w][15:8] : mMem[ob][w][7:0];
                mCpuOutKnown = mKnown[ob][w][cpuA[0]];
            end
            mBusOut      = mMem[bb][mPos];
            mBusOutKnown = &mKnown[bb][mPos];
            if (cpuWe && avail) begin
                if (cpuA[0]) mMem[ob][w][15:8] = cpuDIn;
                else         mMem[ob][w][7:0]  = cpuDIn;
                mKnown[ob][w][cpuA[0]] = 1'b1;
            end
            if (busStrobe && ready && mDir == 1) begin
                mMem[bb][mPos]   = busDIn;
                mKnown[bb][mPos] = 2'b11;
            end
        end
        if (!rstN || !enable) begin
            mCpuBank = 0; mBusBank = 0; mPos = 0; mDone = 1'b0;
            mDir = int'(dir);
            for (int b = 0; b < 2; b++) begin
                mOwn[b] = int'(dir);
                if (dir) mLen[b] = int'(len);
            end
            if (!rstN) mErr = 0;
        end else begin
            if (busStrobe && !ready) newErr |= 1;
            if ((cpuWe || cpuCommit) && !avail) newErr |= 2;
            mErr  = (errClr ? 0 : mErr) | newErr;
            mDone = busStrobe && ready && last;
            if (cpuCommit && avail) begin
                mOwn[ob] = 1; mLen[ob] = int'(len); mCpuBank = 1 - ob;
            end
            if (busStrobe && ready) begin
                if (last) begin
                    mOwn[bb] = 0; mBusBank = 1 - bb; mPos = 0;
                end else begin
                    mPos++;
                end
            end
        end
    endtask

    // One clock: update the model, clock the DUT, compare every output.
    task automatic applyStimulus();
        bit expReady;
        modelStep();
        @(posedge clk);
        #1;
        expReady = enable && (mOwn[mBusBank] == 1);
        checkOutput("cpu_avail", 32'(cpuAvail), 32'(enable && (mOwn[mCpuBank] == 0)));
        checkOutput("bus_ready", 32'(busReady), 32'(expReady));
        checkOutput("bus_last", 32'(busLast), 32'(expReady && (mPos == mLen[mBusBank])));
        checkOutput("cpu_bank", 32'(cpuBank), 32'(mCpuBank));
        checkOutput("bank_done", 32'(bankDone), 32'(mDone));
        checkOutput("err", 32'(err), 32'(mErr));
        if (mCpuOutKnown) checkOutput("cpu_d_out", 32'(cpuDOut), 32'(mCpuOut));
        if (mBusOutKnown) checkOutput("bus_d_out", 32'(busDOut), 32'(mBusOut));
    endtask

    task automatic clearPulses();
        cpuWe = 0; cpuRe = 0; cpuCommit = 0; busStrobe = 0; errClr = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus();
    endtask

    // Strobe once, report bank_done as seen right after, then hold the gap.
    task automatic strobeOnce(input logic [15:0] d, output bit doneSeen);
        busDIn = d; busStrobe = 1;
        applyStimulus();
        doneSeen = bankDone;
        busStrobe = 0;
        idle(2);
    endtask

    task automatic restartIdle(input logic d, input logic [AW-1:0] l);
        enable = 0; dir = d; len = l;
        applyStimulus();
        enable = 1;
    endtask

    initial begin : main
        bit done;
        logic [7:0] rdExp [4];
        int sinceStrobe;
        rdExp[0] = 8'h34; rdExp[1] = 8'h12; rdExp[2] = 8'hCD; rdExp[3] = 8'hAB;
        for (int b = 0; b < 2; b++) begin
            mOwn[b] = 0; mLen[b] = 0;
            for (int i = 0; i < WORDS; i++) begin mMem[b][i] = '0; mKnown[b][i] = 2'b00; end
        end
        mCpuBank = 0; mBusBank = 0; mPos = 0; mDir = 0; mErr = 0; mDone = 0;
        mCpuOut = '0; mBusOut = '0; mCpuOutKnown = 0; mBusOutKnown = 0;
        rstN = 0; enable = 0; dir = 0; len = 0; cpuA = 0; cpuDIn = 0; busDIn = 0;
        clearPulses();
        idle(2);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_bus_d_out", 32'(busDOut), 32'd0);
        rstN = 1;
        idle(1);

        // Single-bank read-out: CPU fills bank 0, bus drains 256 words.
        enable = 1; len = 8'd255;
        for (int i = 0; i < 512; i++) begin
            cpuA = 9'(i); cpuDIn = 8'(i); cpuWe = 1;
            applyStimulus();
        end
        cpuWe = 0; cpuCommit = 1;
        applyStimulus();
        cpuCommit = 0;
        checkOutput("t1_bus_ready", 32'(busReady), 32'd1);
        checkOutput("t1_cpu_avail", 32'(cpuAvail), 32'd1);
        checkOutput("t1_cpu_bank", 32'(cpuBank), 32'd1);
        idle(1);
        for (int k = 0; k < 256; k++) begin
            checkOutput("t1_word", 32'(busDOut), 32'({8'((2 * k + 1) & 255), 8'((2 * k) & 255)}));
            strobeOnce(16'h0000, done);
            if (k == 255) checkOutput("t1_bank_done", 32'(done), 32'd1);
        end
        checkOutput("t1_bus_released", 32'(busReady), 32'd0);

        // Ping-pong with both banks committed.
        restartIdle(1'b0, 8'd3);
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 8; i++) begin
                cpuA = 9'(i); cpuDIn = 8'($urandom); cpuWe = 1;
                applyStimulus();
            end
            cpuWe = 0; cpuCommit = 1;
            applyStimulus();
            cpuCommit = 0;
        end
        checkOutput("t2_cpu_avail_busy", 32'(cpuAvail), 32'd0);
        for (int k = 0; k < 4; k++) strobeOnce(16'h0000, done);
        checkOutput("t2_bus_ready", 32'(busReady), 32'd1);
        checkOutput("t2_cpu_avail", 32'(cpuAvail), 32'd1);
        checkOutput("t2_cpu_bank", 32'(cpuBank), 32'd0);

        // Bus writes, CPU reads back byte lanes.
        restartIdle(1'b1, 8'd1);
        strobeOnce(16'h1234, done);
        strobeOnce(16'hABCD, done);
        checkOutput("t3_bank_done", 32'(done), 32'd1);
        for (int i = 0; i < 4; i++) begin
            cpuA = 9'(i); cpuRe = 1;
            applyStimulus();
            checkOutput("t3_read", 32'(cpuDOut), 32'(rdExp[i]));
        end
        cpuRe = 0; cpuCommit = 1;
        applyStimulus();
        cpuCommit = 0;
        checkOutput("t3_cpu_avail", 32'(cpuAvail), 32'd0);
        strobeOnce(16'h1111, done);
        strobeOnce(16'h2222, done);
        checkOutput("t3_next_ready", 32'(busReady), 32'd1);
        checkOutput("t3_not_last", 32'(busLast), 32'd0);
        strobeOnce(16'h5A5A, done);
        checkOutput("t3_last", 32'(busLast), 32'd1);

        // Error flags.
        errClr = 1; applyStimulus(); errClr = 0;
        restartIdle(1'b0, 8'd3);
        busStrobe = 1; applyStimulus(); busStrobe = 0;
        checkOutput("t4_err_bus", 32'(err), 32'd1);
        idle(1);
        checkOutput("t4_pos_held", 32'(busDOut), 32'h5A5A);
        errClr = 1; applyStimulus(); errClr = 0;
        checkOutput("t4_err_clr", 32'(err), 32'd0);
        cpuCommit = 1; idle(2); cpuCommit = 0;
        cpuA = 0; cpuDIn = 8'hFF; cpuWe = 1; applyStimulus(); cpuWe = 0;
        checkOutput("t4_err_cpu", 32'(err), 32'd2);
        cpuRe = 1; applyStimulus(); cpuRe = 0;
        checkOutput("t4_ram_kept", 32'(cpuDOut), 32'h5A);

        // Commit of bank 1 coinciding with the final strobe of bank 0.
        errClr = 1; applyStimulus(); errClr = 0;
        restartIdle(1'b0, 8'd0);
        cpuCommit = 1; applyStimulus(); cpuCommit = 0;
        idle(2);
        cpuCommit = 1; busStrobe = 1; applyStimulus(); cpuCommit = 0; busStrobe = 0;
        checkOutput("t5_cpu_avail", 32'(cpuAvail), 32'd1);
        checkOutput("t5_cpu_bank", 32'(cpuBank), 32'd0);
        checkOutput("t5_bus_ready", 32'(busReady), 32'd1);
        checkOutput("t5_err", 32'(err), 32'd0);
        idle(2);

        // Mid-bank reset, then mid-bank disable.
        for (int pass = 0; pass < 2; pass++) begin
            restartIdle(1'b0, 8'd3);
            busStrobe = 1; applyStimulus(); busStrobe = 0;
            cpuCommit = 1; applyStimulus(); cpuCommit = 0;
            idle(2);
            strobeOnce(16'h0000, done);
            strobeOnce(16'h0000, done);
            cpuA = 9'd1; cpuRe = 1; applyStimulus(); cpuRe = 0;
            if (pass == 0) begin
                rstN = 0; applyStimulus();
                checkOutput("t6_rst_err", 32'(err), 32'd0);
                checkOutput("t6_rst_cpu_d", 32'(cpuDOut), 32'd0);
                checkOutput("t6_rst_bus_d", 32'(busDOut), 32'd0);
                checkOutput("t6_rst_avail", 32'(cpuAvail), 32'd1);
                rstN = 1;
            end else begin
                enable = 0; applyStimulus();
                checkOutput("t6_dis_err", 32'(err), 32'd1);
                checkOutput("t6_dis_avail", 32'(cpuAvail), 32'd0);
                checkOutput("t6_dis_bank", 32'(cpuBank), 32'd0);
                enable = 1;
            end
            checkOutput("t6_bus_ready", 32'(busReady), 32'd0);
            idle(1);
        end

        // Randomized traffic against the model.
        sinceStrobe = 3;
        for (int c = 0; c < 5000; c++) begin
            rstN      = ($urandom_range(0, 299) != 0);
            enable    = enable ? ($urandom_range(0, 59) != 0) : 1'($urandom_range(0, 1));
            dir       = 1'($urandom_range(0, 1));
            len       = ($urandom_range(0, 7) == 0) ? 8'd255 : 8'($urandom_range(0, 3));
            cpuA      = 9'($urandom_range(0, 511));
            cpuDIn    = 8'($urandom);
            cpuWe     = ($urandom_range(0, 3) == 0);
            cpuRe     = ($urandom_range(0, 3) == 0);
            cpuCommit = ($urandom_range(0, 15) == 0);
            errClr    = ($urandom_range(0, 31) == 0);
            busDIn    = 16'($urandom);
            busStrobe = (sinceStrobe >= 2) && ($urandom_range(0, 1) == 1);
            sinceStrobe = busStrobe ? 0 : sinceStrobe + 1;
            applyStimulus();
        end
        clearPulses();
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
